// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int FRAME_BITS          = 11;
  localparam int DATA_BITS           = 8;
  localparam int TIMEOUT_CYC_DEFAULT = 50000;

  // True when the data byte plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_sync_fifo.sv
// Generic synchronous FIFO (module sync_fifo) with count; push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: oversampled pins, start/parity/stop validation, scan-code FIFO.
// Define PS2_RX_TIMEOUT_EN to abort stalled partial frames after TIMEOUT_CYC cycles.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_ready,
  input  logic                 clr_flags,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  ps2_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  logic                   timeout;
  logic                   stop_fall;
  logic                   good_frame;
  logic                   bad_frame;
  logic                   push_req;
  logic                   pop;
  logic                   ovf_set;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign fall        = clk_prev_q & ~clk_s;

  // Synchronizers idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d[cnt_q] = data_s;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_BITS-1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still takes a good frame if the consumer pops in the same cycle.
  always_comb begin
    stop_fall   = fall & (state_q == STOP) & ~timeout;
    good_frame  = stop_fall & data_s & odd_parity_ok(shreg_q, par_q);
    bad_frame   = stop_fall & ~good_frame;
    pop         = rd_valid & rd_ready;
    push_req    = good_frame;
    ovf_set     = good_frame & fifo_full & ~pop;
    overflow_d  = ovf_set | (overflow_q & ~clr_flags);
    frame_err_d = bad_frame | timeout;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if ((state_q == IDLE) || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC-1)) begin
      to_cnt_d = '0;
      timeout  = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .wr_data (shreg_q),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  assign rd_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: stimulus queues expected scan codes, a monitor
// checks every handshake pop and counts frame_err pulses.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int SYNC  = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_ready;
  logic       clr_flags;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overflow;

  int         vecCount = 0;
  int         missCount = 0;
  int         errSeen = 0;
  int         errExpected = 0;
  logic [7:0] expQ [$];
  logic [7:0] expByte;

  always #5 clk = ~clk;

  ps2_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_ready  (rd_ready),
    .clr_flags (clr_flags),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Monitor: every accepted handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) errSeen++;
      if (rd_valid && rd_ready) begin
        vecCount++;
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL unexpected_pop: got %02h, required no data", rd_data);
        end else begin
          expByte = expQ.pop_front();
          if (rd_data !== expByte) begin
            missCount++;
            $display("[TB] FAIL pop_data: got %02h, required %02h", rd_data, expByte);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vecCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Sends the first nBits bits of a frame; popAtStop raises rd_ready only in the stop-bit fall cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit badParity, input bit popAtStop, input int nBits);
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, (~^data) ^ badParity, data, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = frame[i];
      tick(5);
      ps2_clk = 1'b0;
      if (popAtStop && i == FRAME_BITS-1) begin
        tick(SYNC);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(10 - SYNC - 1);
      end else begin
        tick(10);
      end
      ps2_clk = 1'b1;
      tick(5);
    end
    ps2_data = 1'b1;
    tick(5);
  endtask

  task automatic drainFifo(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (expQ.size() == 0 && !rd_valid) break;
      tick(1);
    end
    rd_ready = 1'b0;
    tick(1);
    checkOutput({name, "_queue_left"}, expQ.size(), 0);
    checkOutput({name, "_rd_valid"}, rd_valid, 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    rd_ready  = 1'b0;
    clr_flags = 1'b0;
    tick(3);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(3);
    checkOutput("post_reset_rd_valid", rd_valid, 0);

    // Single good frame 0x1C, held until read.
    applyStimulus(8'h1C, 1'b0, 1'b0, FRAME_BITS);
    tick(2);
    checkOutput("good_rd_valid", rd_valid, 1);
    checkOutput("good_rd_data", rd_data, 8'h1C);
    checkOutput("good_err_count", errSeen, errExpected);
    checkOutput("good_overflow", overflow, 0);
    expQ.push_back(8'h1C);
    drainFifo("good");

    // Bad parity: one frame_err pulse, nothing stored.
    applyStimulus(8'h1C, 1'b1, 1'b0, FRAME_BITS);
    errExpected++;
    tick(2);
    checkOutput("badpar_err_count", errSeen, errExpected);
    checkOutput("badpar_rd_valid", rd_valid, 0);
    checkOutput("badpar_frame_err_low", frame_err, 0);

    // Nine frames into an eight-entry FIFO: the ninth overflows.
    for (int v = 1; v <= 9; v++) begin
      applyStimulus(8'(v), 1'b0, 1'b0, FRAME_BITS);
      if (v <= DEPTH) expQ.push_back(8'(v));
      if (v == DEPTH) checkOutput("fill_no_overflow", overflow, 0);
    end
    tick(2);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_head", rd_data, 8'h01);
    drainFifo("ovf");
    checkOutput("ovf_sticky", overflow, 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);

    // Full FIFO with a pop coinciding with the stop-bit fall.
    for (int v = 8'h10; v < 8'h10 + DEPTH; v++) begin
      applyStimulus(8'(v), 1'b0, 1'b0, FRAME_BITS);
      expQ.push_back(8'(v));
    end
    checkOutput("full_head", rd_data, 8'h10);
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b0, 1'b1, FRAME_BITS);
    tick(2);
    checkOutput("simul_no_overflow", overflow, 0);
    checkOutput("simul_head", rd_data, 8'h11);
    drainFifo("simul");

    // Reset in the middle of a frame discards it.
    applyStimulus(8'hA5, 1'b0, 1'b0, 5);
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(2);
    checkOutput("midrst_rd_valid", rd_valid, 0);
    checkOutput("midrst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(2);
    expQ.push_back(8'hF0);
    applyStimulus(8'hF0, 1'b0, 1'b0, FRAME_BITS);
    tick(2);
    checkOutput("midrst_rd_data", rd_data, 8'hF0);
    checkOutput("midrst_err_count", errSeen, errExpected);
    drainFifo("midrst");

`ifdef PS2_RX_TIMEOUT_EN
    // Stalled partial frame is aborted; the next frame is clean.
    applyStimulus(8'h2A, 1'b0, 1'b0, 4);
    tick(150);
    errExpected++;
    checkOutput("timeout_err_count", errSeen, errExpected);
    checkOutput("timeout_rd_valid", rd_valid, 0);
    expQ.push_back(8'h2A);
    applyStimulus(8'h2A, 1'b0, 1'b0, FRAME_BITS);
    tick(2);
    checkOutput("timeout_next_data", rd_data, 8'h2A);
    drainFifo("timeout");
`endif

    checkOutput("final_err_count", errSeen, errExpected);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Upstream stage of the shift/display datapath: receives PS/2 keyboard frames on ps2_clk/ps2_data and validates start, parity and stop bits.
- Buffers accepted scan codes in a small FIFO.
- Presents codes to the downstream consumer (shift register control or scan-code decoder) through a valid/ready handshake.
- Everything runs in the clk domain; PS/2 pins are oversampled.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2.
- SYNC_STAGES, 3, flip-flop stages on ps2_clk and ps2_data; at least 2.
- TIMEOUT_CYC, 50000, clk cycles without a falling ps2_clk edge before a partial frame is aborted; used only with PS2_RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ps2_clk  input  1  PS/2 clock pin, asynchronous.
- ps2_data  input  1  PS/2 data pin, asynchronous.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- clr_flags  input  1  synchronous clear of the sticky overflow flag.
- rd_valid  output  1  FIFO non-empty; rd_data is valid.
- rd_data  output  8  oldest scan code.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- overflow  output  1  sticky; set when a good frame is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, bit counter 0, synchronizers reset to 1 (idle bus level). Reset mid-frame discards the partial frame.
- Synchronization and edge detect:
  - Both pins pass through SYNC_STAGES flops.
  - fall = previous synced ps2_clk is 1 and current is 0; fall is one clk cycle wide.
  - Data is sampled from synced ps2_data in the cycle fall is high.
- Frame format: 11 bits, LSB first.
  - Start 0, D0..D7, odd parity (the ones count over D0..D7 plus P is odd), stop 1.
- State machine, advancing only on fall:
  - IDLE: if the sampled bit is 0, go to DATA with cnt=0. If it is 1, stay in IDLE (glitch or idle); no error is raised.
  - DATA: shift the bit into shreg at position cnt and increment cnt. After the 8th bit (cnt==7), go to PARITY.
  - PARITY: latch P, go to STOP.
  - STOP: evaluate the frame and go to IDLE.
    - Good frame = stop==1 and parity odd.
    - Good frame with FIFO not full, or full with a pop in the same cycle: push shreg.
    - Good frame with FIFO full and no pop: drop it and set overflow.
    - Bad frame: pulse frame_err in the next cycle, no push.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth; a separate count field is log2(FIFO_DEPTH)+1 bits.
  - Pop occurs when rd_valid and rd_ready are both high.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds when full and when there is exactly one entry.
  - Pop while empty is ignored.
  - rd_data = mem[rptr], registered read-through. rd_valid = (count != 0).
- Latency: rd_valid rises 1 clk cycle after the STOP-state fall cycle when the FIFO was empty. Pin-to-fall latency is SYNC_STAGES cycles.
- overflow stays at 1 until clr_flags or reset. If clr_flags and a new overflow occur in the same cycle, set wins.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while the state is not IDLE and resets on every fall.
  - When it reaches TIMEOUT_CYC-1, the state returns to IDLE, the counter clears, frame_err pulses one cycle, and nothing is pushed.
  - The counter holds at 0 in IDLE.
- Without the macro: no counter is built. A stalled partial frame waits indefinitely and completes with the next falling edges.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - FRAME_BITS=11 and DATA_BITS=8;
  - the default TIMEOUT_CYC constant.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. It is reused later by the display path.
- The synchronizer stays inline.

Test Plan:
- Send frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, P=0, stop 1), rd_ready=0 -> rd_valid=1, rd_data=0x1C; frame_err=0, overflow=0.
- Send 0x1C with P=1 -> frame_err one-cycle pulse, rd_valid stays 0.
- Send 9 good frames 0x01..0x09 with rd_ready=0 -> 8 entries; overflow=1 after the 9th; popping yields 0x01..0x08 in order; clr_flags -> overflow=0.
- FIFO full; hold rd_ready=1 while the stop-bit fall of 0x55 arrives -> no overflow; the last pop returns 0x55.
- Assert rst_n=0 after 5 bits of a frame, release, send 0xF0 -> only 0xF0 received, no frame_err.
- With PS2_RX_TIMEOUT_EN defined and TIMEOUT_CYC=100: stop toggling ps2_clk after 4 bits -> frame_err pulse at cycle 100; the following frame 0x2A is received correctly.
